fp_add_seq_ctrl: RTL and testbench

//  Multi-cycle IEEE-754 single-precision adder/subtractor built around the existing magnitude comparator.
//  The FSM sequences four phases: compare/order, iterative mantissa alignment, add/sub, iterative normalise.

---
 rtl/fp32_pkg.sv | 32 +++
 rtl/fp_add_seq_ctrl_if.sv | 12 +
 rtl/fp_add_seq_ctrl_cmp.sv | 22 ++
 rtl/fp_add_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fp_add_seq_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, FSM state encoding and field helpers
// used by the sequential adder and its comparator.
package fp32_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMP   = 3'd1,
    ST_ALIGN = 3'd2,
    ST_ADD   = 3'd3,
    ST_NORM  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic f_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [31:0] v);
    return v[22:0];
  endfunction

endpackage

// File: rtl/fp_add_seq_ctrl_if.sv
// Start/busy/done operation handshake between the ALU op decoder and the sequential adder.
interface fp_add_seq_ctrl_if;
  logic        start;
  logic [31:0] X;
  logic [31:0] Y;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, X, Y, input busy, done, result);
  modport slave  (input start, X, Y, output busy, done, result);
endinterface

// File: rtl/fp_add_seq_ctrl_cmp.sv
// Magnitude comparator: orders two floats by |value| and reports the exponent gap.
module fp_add_seq_ctrl_cmp
  import fp32_pkg::*;
(
  input  logic [31:0]      X,
  input  logic [31:0]      Y,
  output logic [EXP_W-1:0] dif,
  output logic [31:0]      outB,
  output logic [31:0]      outL
);

  logic x_ge;

  // Exponent and mantissa concatenated compare as one unsigned magnitude.
  always_comb begin
    x_ge = (X[30:0] >= Y[30:0]);
    outB = x_ge ? X : Y;
    outL = x_ge ? Y : X;
    dif  = f_exp(outB) - f_exp(outL);
  end

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle single-precision adder/subtractor: compare/order, iterative align,
// add/sub, iterative normalise. Truncating, denormals flushed to zero.
module fp_add_seq_ctrl
  import fp32_pkg::*;
#(
  parameter int unsigned ALIGN_LIMIT = 26
) (
  input  logic             clk,
  input  logic             rst,
  fp_add_seq_ctrl_if.slave bus
);

  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned SW = MAN_W + 2;

  state_e           state_q, state_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [MW-1:0]    big_m_q, big_m_d;
  logic [MW-1:0]    lit_m_q, lit_m_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic             sign_q, sign_d;
  logic             sub_q, sub_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      result_q, result_d;

  logic [EXP_W-1:0] cmp_dif;
  logic [31:0]      cmp_b;
  logic [31:0]      cmp_l;
  logic             special;
  logic [31:0]      special_res;

  fp_add_seq_ctrl_cmp u_cmp (
    .X    (opa_q),
    .Y    (opb_q),
    .dif  (cmp_dif),
    .outB (cmp_b),
    .outL (cmp_l)
  );

  // Inf/NaN on the big side, or zero on the little side, bypass the datapath.
  always_comb begin
    special     = (f_exp(cmp_b) == EXP_MAX) || (f_exp(cmp_l) == '0);
    special_res = cmp_b;
    if ((f_exp(cmp_b) == EXP_MAX) && (f_exp(cmp_l) == EXP_MAX) &&
        (f_man(cmp_b) == '0) && (f_man(cmp_l) == '0) &&
        (f_sign(cmp_b) != f_sign(cmp_l))) begin
      special_res = QNAN;
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    big_m_d  = big_m_q;
    lit_m_d  = lit_m_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opa_d   = bus.X;
          opb_d   = bus.Y;
          state_d = ST_CMP;
        end
      end

      ST_CMP: begin
        sign_d  = f_sign(cmp_b);
        sub_d   = f_sign(cmp_b) ^ f_sign(cmp_l);
        exp_d   = f_exp(cmp_b);
        big_m_d = {1'b1, f_man(cmp_b)};
        lit_m_d = {1'b1, f_man(cmp_l)};
        cnt_d   = cmp_dif;
        if (special) begin
          result_d = special_res;
          state_d  = ST_DONE;
        end else if (cmp_dif == '0) begin
          state_d = ST_ADD;
        end else if (cmp_dif >= EXP_W'(ALIGN_LIMIT)) begin
          lit_m_d = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        lit_m_d = lit_m_q >> 1;
        cnt_d   = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) state_d = ST_ADD;
      end

      ST_ADD: begin
        sum_d   = sub_q ? ({1'b0, big_m_q} - {1'b0, lit_m_q})
                        : ({1'b0, big_m_q} + {1'b0, lit_m_q});
        state_d = ST_NORM;
      end

      // Carry out takes one right shift; leading zeros shift left one per cycle.
      ST_NORM: begin
        if (sum_q == '0) begin
          result_d = '0;
          state_d  = ST_DONE;
        end else if (sum_q[SW-1]) begin
          sum_d   = sum_q >> 1;
          exp_d   = exp_q + EXP_W'(1);
          if (exp_q == (EXP_MAX - EXP_W'(1))) begin
            result_d = {sign_q, EXP_MAX, MAN_W'(0)};
          end else begin
            result_d = {sign_q, exp_q + EXP_W'(1), sum_q[MAN_W:1]};
          end
          state_d = ST_DONE;
        end else if (!sum_q[MAN_W]) begin
          if (exp_q == EXP_W'(1)) begin
            result_d = '0;
            state_d  = ST_DONE;
          end else begin
            sum_d = sum_q << 1;
            exp_d = exp_q - EXP_W'(1);
          end
        end else begin
          result_d = {sign_q, exp_q, sum_q[MAN_W-1:0]};
          state_d  = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CMP) || (state_d == ST_ALIGN) ||
             (state_d == ST_ADD) || (state_d == ST_NORM);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      big_m_q  <= '0;
      lit_m_q  <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      big_m_q  <= big_m_d;
      lit_m_q  <= lit_m_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Directed vector bench for the sequential fp adder, plus handshake and reset sequences.
module tb_fp_add_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_add_seq_ctrl_if bus ();

  fp_add_seq_ctrl #(.ALIGN_LIMIT(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One start pulse; cyc is the cycle (1 = first after start) in which done was seen, -1 on timeout.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int cyc, output logic done_after);
    @(negedge clk);
    bus.X = x;
    bus.Y = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    res = bus.result;
    if (bus.done !== 1'b1) cyc = -1;
    @(negedge clk);
    done_after = bus.done;
  endtask

  logic [31:0] res;
  int          cyc;
  logic        done_after;
  int          ndone;
  int          done_cyc;

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 4};
    vecs[1]  = '{32'h40400000, 32'hBF800000, 32'h40000000, 5};
    vecs[2]  = '{32'h3FC00000, 32'hBFC00000, 32'h00000000, 4};
    vecs[3]  = '{32'h3F800000, 32'h30800000, 32'h3F800000, 4};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4};
    vecs[5]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 2};
    vecs[6]  = '{32'h3F800000, 32'h00000000, 32'h3F800000, 2};
    vecs[7]  = '{32'h40000000, 32'h3F800000, 32'h40400000, 5};
    vecs[8]  = '{32'h3F800000, 32'hBF000000, 32'h3F000000, 6};
    vecs[9]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 28};
    vecs[10] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 2};
    vecs[11] = '{32'h00800000, 32'h80800001, 32'h00000000, 4};
    vecs[12] = '{32'hC0000000, 32'hC0000000, 32'hC0800000, 4};
    vecs[13] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2};
    vecs[14] = '{32'h00000000, 32'hBF800000, 32'hBF800000, 2};
    vecs[15] = '{32'h3F800001, 32'hBF800000, 32'h34000000, 27};

    bus.start = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_int("reset_busy", int'(bus.busy), 0);
    check_int("reset_done", int'(bus.done), 0);
    check32("reset_result", bus.result, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].x, vecs[i].y, res, cyc, done_after);
      check32($sformatf("vec%0d_result", i), res, vecs[i].r);
      check_int($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
      check_int($sformatf("vec%0d_done_pulse", i), int'(done_after), 0);
    end

    // Start while busy and start during the DONE cycle are both ignored.
    @(negedge clk);
    bus.X = 32'h3F800000;
    bus.Y = 32'h33800000;
    bus.start = 1'b1;
    ndone = 0;
    done_cyc = -1;
    res = '0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 3) begin
        check_int("hs_busy", int'(bus.busy), 1);
        bus.X = 32'h40000000;
        bus.Y = 32'h40000000;
        bus.start = 1'b1;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        res = bus.result;
        done_cyc = c;
        bus.X = 32'h40000000;
        bus.Y = 32'h40000000;
        bus.start = 1'b1;
      end
    end
    bus.start = 1'b0;
    check_int("hs_done_count", ndone, 1);
    check_int("hs_done_cycle", done_cyc, 28);
    check32("hs_result", res, 32'h3F800000);

    // Reset in the middle of alignment discards the operation.
    @(negedge clk);
    bus.X = 32'h3F800000;
    bus.Y = 32'h36000000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check_int("rst_pre_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_done", int'(bus.done), 0);
    check32("rst_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check_int("rst_no_done", ndone, 0);

    run_op(32'h3F800000, 32'h36000000, res, cyc, done_after);
    check32("post_rst_result", res, 32'h3F800010);
    check_int("post_rst_latency", cyc, 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
